// File: rtl/uart_pkg.sv
// Shared UART definitions: parity-mode encodings and the serializer FSM states,
// kept here so the receive side can reuse the same encodings.
package uart_pkg;

    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_EVEN = 2'b01;
    localparam logic [1:0] PAR_ODD  = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_e;

    // Mode 2'b11 is an alias for "no parity".
    function automatic logic par_enabled(input logic [1:0] mode);
        return (mode == PAR_EVEN) || (mode == PAR_ODD);
    endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 while run is high, held at 0
// otherwise, and flags the last cycle of every bit period.
module uart_bit_timer #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    output logic bit_end
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (!run || (cnt_q == LAST)) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign bit_end = run && (cnt_q == LAST);

endmodule

// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: start bit, DATA_W data bits (LSB or MSB first),
// optional parity, one or two stop bits, on a flop-driven idle-high line.
module uart_tx_serializer
    import uart_pkg::*;
#(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    input  logic [1:0]        par_mode,
    input  logic              stop2,
    input  logic              msb_first,
    output logic              tx_out,
    output logic              tx_busy,
    output logic              tx_done,
    output uart_state_e       dbg_state
);

    localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);

    uart_state_e       state_q;
    logic [DATA_W-1:0] data_q;
    logic [1:0]        par_q;
    logic              stop2_q;
    logic              msb_q;
    logic [IDX_W-1:0]  idx_q;
    logic              stop_cnt_q;
    logic              tx_out_q;

    logic              run;
    logic              bit_end;
    logic [IDX_W-1:0]  idx_d;
    logic              first_bit;
    logic              next_bit;
    logic              parity_bit;
    logic              last_stop;

    function automatic logic pick_bit(input logic [DATA_W-1:0] d, input logic msb,
                                      input logic [IDX_W-1:0] i);
        return msb ? d[IDX_LAST - i] : d[i];
    endfunction

    assign run        = (state_q != ST_IDLE);
    assign idx_d      = idx_q + IDX_W'(1);
    assign first_bit  = pick_bit(data_q, msb_q, '0);
    assign next_bit   = pick_bit(data_q, msb_q, idx_d);
    assign parity_bit = (^data_q) ^ (par_q == PAR_ODD);
    assign last_stop  = !stop2_q || stop_cnt_q;

    uart_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_bit_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .run    (run),
        .bit_end(bit_end)
    );

    // Handshake: a frame transfers on a rising edge where tx_valid && tx_ready;
    // tx_ready is high only in IDLE, and inputs are ignored at every other time.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            data_q     <= '0;
            par_q      <= '0;
            stop2_q    <= 1'b0;
            msb_q      <= 1'b0;
            idx_q      <= '0;
            stop_cnt_q <= 1'b0;
            tx_out_q   <= 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (tx_valid) begin
                        data_q     <= tx_data;
                        par_q      <= par_mode;
                        stop2_q    <= stop2;
                        msb_q      <= msb_first;
                        idx_q      <= '0;
                        stop_cnt_q <= 1'b0;
                        tx_out_q   <= 1'b0;
                        state_q    <= ST_START;
                    end
                end
                ST_START: begin
                    if (bit_end) begin
                        tx_out_q <= first_bit;
                        state_q  <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (bit_end) begin
                        if (idx_q == IDX_LAST) begin
                            if (par_enabled(par_q)) begin
                                tx_out_q <= parity_bit;
                                state_q  <= ST_PARITY;
                            end else begin
                                tx_out_q <= 1'b1;
                                state_q  <= ST_STOP;
                            end
                        end else begin
                            idx_q    <= idx_d;
                            tx_out_q <= next_bit;
                        end
                    end
                end
                ST_PARITY: begin
                    if (bit_end) begin
                        tx_out_q <= 1'b1;
                        state_q  <= ST_STOP;
                    end
                end
                ST_STOP: begin
                    if (bit_end) begin
                        if (last_stop) begin
                            tx_out_q <= 1'b1;
                            state_q  <= ST_IDLE;
                        end else begin
                            stop_cnt_q <= 1'b1;
                        end
                    end
                end
                default: begin
                    tx_out_q <= 1'b1;
                    state_q  <= ST_IDLE;
                end
            endcase
        end
    end

    // tx_done is decoded purely from flops: the final cycle of the last stop bit.
    assign tx_done   = (state_q == ST_STOP) && bit_end && last_stop;
    assign tx_ready  = (state_q == ST_IDLE);
    assign tx_busy   = !tx_ready;
    assign tx_out    = tx_out_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Self-checking bench for uart_tx_serializer: an 8-bit and a 5-bit instance,
// each compared every cycle against a frame-level model of the serial line.
module tb_uart_tx_serializer;
  import uart_pkg::*;

  localparam int CPB = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  bit   chk_en = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic [7:0]  a_data = '0;
  logic        a_valid = 1'b0;
  logic [1:0]  a_par = '0;
  logic        a_stop2 = 1'b0;
  logic        a_msb = 1'b0;
  logic        a_ready, a_out, a_busy, a_done;
  uart_state_e a_state;

  logic [4:0]  b_data = '0;
  logic        b_valid = 1'b0;
  logic [1:0]  b_par = '0;
  logic        b_stop2 = 1'b0;
  logic        b_msb = 1'b0;
  logic        b_ready, b_out, b_busy, b_done;
  uart_state_e b_state;

  uart_tx_serializer #(.DATA_W(8), .CLKS_PER_BIT(CPB)) dut_a (
    .clk(clk), .rst_n(rst_n), .tx_data(a_data), .tx_valid(a_valid), .tx_ready(a_ready),
    .par_mode(a_par), .stop2(a_stop2), .msb_first(a_msb), .tx_out(a_out),
    .tx_busy(a_busy), .tx_done(a_done), .dbg_state(a_state)
  );

  uart_tx_serializer #(.DATA_W(5), .CLKS_PER_BIT(CPB)) dut_b (
    .clk(clk), .rst_n(rst_n), .tx_data(b_data), .tx_valid(b_valid), .tx_ready(b_ready),
    .par_mode(b_par), .stop2(b_stop2), .msb_first(b_msb), .tx_out(b_out),
    .tx_busy(b_busy), .tx_done(b_done), .dbg_state(b_state)
  );

  int vectors = 0;
  int errors  = 0;

  // Expected per-cycle {tx_out, tx_done} for each instance while a frame is in flight.
  logic [1:0] exp_a_q[$];
  logic [1:0] exp_b_q[$];

  // ---------------- reference model ----------------
  // Frame as a bit list, first-sent bit in the MSB of the n-bit value v.
  function automatic void frame_bits(input logic [8:0] data, input int dw, input logic [1:0] par,
                                     input logic s2, input logic msb,
                                     output logic [15:0] v, output int n);
    logic [8:0] sh;
    logic       p;
    int         idx;
    v = '0;
    n = 0;
    v = {v[14:0], 1'b0}; n++;
    p = 1'b0;
    for (int i = 0; i < dw; i++) begin
      idx = msb ? (dw - 1 - i) : i;
      sh  = data >> idx;
      v   = {v[14:0], sh[0]}; n++;
      sh  = data >> i;
      p   = p ^ sh[0];
    end
    if (par == 2'b01) begin v = {v[14:0], p}; n++; end
    else if (par == 2'b10) begin v = {v[14:0], ~p}; n++; end
    v = {v[14:0], 1'b1}; n++;
    if (s2) begin v = {v[14:0], 1'b1}; n++; end
  endfunction

  function automatic int frame_len(input int dw, input logic [1:0] par, input logic s2);
    int p;
    int s;
    p = (par == 2'b01 || par == 2'b10) ? 1 : 0;
    s = s2 ? 2 : 1;
    return (1 + dw + p + s) * CPB;
  endfunction

  function automatic void push_frame(input bit sel, input logic [15:0] v, input int n);
    logic [15:0] sh;
    logic [1:0]  e;
    for (int k = n - 1; k >= 0; k--) begin
      sh = v >> k;
      for (int c = 0; c < CPB; c++) begin
        e = {sh[0], (k == 0 && c == CPB - 1) ? 1'b1 : 1'b0};
        if (sel) exp_b_q.push_back(e);
        else exp_a_q.push_back(e);
      end
    end
  endfunction

  // ---------------- scoreboard ----------------
  task automatic check_val(input string name, input int got, input int want);
    vectors++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, want, $time);
    end
  endtask

  task automatic check_side(input bit sel);
    logic [3:0]  got;
    logic [3:0]  want;
    logic [1:0]  e;
    logic [15:0] v;
    int          n;
    int          qn;
    got = sel ? {b_out, b_ready, b_busy, b_done} : {a_out, a_ready, a_busy, a_done};
    qn  = sel ? exp_b_q.size() : exp_a_q.size();
    if (!rst_n) begin
      if (sel) exp_b_q.delete();
      else exp_a_q.delete();
      want = 4'b1100;
    end else if (qn == 0) begin
      want = 4'b1100;
      if (sel && b_valid) begin
        frame_bits({4'b0, b_data}, 5, b_par, b_stop2, b_msb, v, n);
        push_frame(1'b1, v, n);
      end else if (!sel && a_valid) begin
        frame_bits({1'b0, a_data}, 8, a_par, a_stop2, a_msb, v, n);
        push_frame(1'b0, v, n);
      end
    end else begin
      if (sel) e = exp_b_q.pop_front();
      else e = exp_a_q.pop_front();
      want = {e[1], 1'b0, 1'b1, e[0]};
    end
    vectors++;
    if (got !== want) begin
      errors++;
      $display("FAIL line_%s t=%0t: out/ready/busy/done got %b expected %b",
               sel ? "w5" : "w8", $time, got, want);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check_side(1'b0);
      check_side(1'b1);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic scramble(input bit sel);
    if (sel) begin
      b_data  = 5'($urandom_range(0, 31));
      b_par   = 2'($urandom_range(0, 3));
      b_stop2 = 1'($urandom_range(0, 1));
      b_msb   = 1'($urandom_range(0, 1));
    end else begin
      a_data  = 8'($urandom_range(0, 255));
      a_par   = 2'($urandom_range(0, 3));
      a_stop2 = 1'($urandom_range(0, 1));
      a_msb   = 1'($urandom_range(0, 1));
    end
  endtask

  // Called at posedge+1; returns at posedge+1 of the first cycle after accept.
  task automatic send(input bit sel, input logic [8:0] data, input logic [1:0] par,
                      input logic s2, input logic msb, input bit hold);
    bit acc;
    acc = 1'b0;
    if (sel) begin
      b_data = data[4:0]; b_par = par; b_stop2 = s2; b_msb = msb; b_valid = 1'b1;
    end else begin
      a_data = data[7:0]; a_par = par; a_stop2 = s2; a_msb = msb; a_valid = 1'b1;
    end
    for (int i = 0; i < 200 && !acc; i++) begin
      @(negedge clk);
      acc = (sel ? b_ready : a_ready) && rst_n;
      @(posedge clk);
      #1;
    end
    if (!acc) check_val("accept_timeout", 0, 1);
    if (!hold) begin
      if (sel) b_valid = 1'b0;
      else a_valid = 1'b0;
    end
  endtask

  // Counts cycles up to and including the tx_done cycle; returns at posedge+1.
  task automatic wait_done(input bit sel, input bit noise, output int cyc);
    bit seen;
    seen = 1'b0;
    cyc  = 0;
    while (!seen && cyc < 300) begin
      @(negedge clk);
      cyc++;
      if (sel ? b_done : a_done) seen = 1'b1;
      @(posedge clk);
      #1;
      if (noise && !seen) scramble(sel);
    end
    if (!seen) check_val("done_timeout", 0, 1);
  endtask

  // ---------------- stimulus ----------------
  initial begin : main
    logic [15:0] v;
    int          n;
    int          c;
    int          gap;
    logic [8:0]  d;
    logic [1:0]  p;
    logic        s;
    logic        m;

    // Hand-computed frames pin the model itself.
    frame_bits(9'h0A5, 8, 2'b00, 1'b0, 1'b0, v, n);
    check_val("model_a5_len", n, 10);
    check_val("model_a5_bits", int'(v), 'h14B);
    frame_bits(9'h007, 8, 2'b01, 1'b0, 1'b0, v, n);
    check_val("model_even07", int'(v), 'h383);
    frame_bits(9'h007, 8, 2'b10, 1'b0, 1'b0, v, n);
    check_val("model_odd07", int'(v), 'h381);
    frame_bits(9'h080, 8, 2'b00, 1'b1, 1'b1, v, n);
    check_val("model_80_msb_s2", int'(v), 'h203);
    frame_bits(9'h015, 5, 2'b11, 1'b0, 1'b0, v, n);
    check_val("model_w5_len", n, 7);
    check_val("model_w5_bits", int'(v), 'h2B);

    #1 rst_n = 1'b0;
    #1 chk_en = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_val("reset_out", int'(a_out), 1);
    check_val("reset_ready", int'(a_ready), 1);
    check_val("reset_busy", int'(a_busy), 0);
    check_val("reset_state", int'(a_state), int'(ST_IDLE));
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 8N1 0xA5, LSB first
    send(1'b0, 9'h0A5, 2'b00, 1'b0, 1'b0, 1'b0);
    wait_done(1'b0, 1'b1, c);
    check_val("len_8n1_a5", c, 40);

    // even / odd parity 0x07
    send(1'b0, 9'h007, 2'b01, 1'b0, 1'b0, 1'b0);
    wait_done(1'b0, 1'b1, c);
    check_val("len_even_07", c, 44);
    send(1'b0, 9'h007, 2'b10, 1'b0, 1'b0, 1'b0);
    wait_done(1'b0, 1'b1, c);
    check_val("len_odd_07", c, 44);

    // MSB first, two stop bits, 0x80
    send(1'b0, 9'h080, 2'b00, 1'b1, 1'b1, 1'b0);
    wait_done(1'b0, 1'b1, c);
    check_val("len_msb_s2_80", c, 44);

    // tx_valid held high: 0x01 then 0xFF, data changed mid-frame
    send(1'b0, 9'h001, 2'b00, 1'b0, 1'b0, 1'b1);
    a_data = 8'hFF;
    wait_done(1'b0, 1'b0, c);
    check_val("len_b2b_first", c, 40);
    gap = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (a_busy) break;
      gap++;
      @(posedge clk);
      #1;
    end
    @(posedge clk);
    #1;
    a_valid = 1'b0;
    check_val("b2b_idle_gap", gap, 1);
    wait_done(1'b0, 1'b1, c);
    check_val("len_b2b_second", c, 39);

    // Reset during data bit 2 of 0xC3 (that bit is 0)
    send(1'b0, 9'h0C3, 2'b00, 1'b0, 1'b0, 1'b0);
    repeat (13) @(posedge clk);
    #2;
    check_val("pre_reset_state", int'(a_state), int'(ST_DATA));
    check_val("pre_reset_out", int'(a_out), 0);
    rst_n = 1'b0;
    #1;
    check_val("async_reset_out", int'(a_out), 1);
    check_val("async_reset_done", int'(a_done), 0);
    check_val("async_reset_ready", int'(a_ready), 1);
    repeat (3) @(posedge clk);
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    send(1'b0, 9'h03C, 2'b00, 1'b0, 1'b0, 1'b0);
    wait_done(1'b0, 1'b1, c);
    check_val("len_after_reset_3c", c, 40);

    // Randomized 8-bit frames
    for (int i = 0; i < 16; i++) begin
      d = 9'($urandom_range(0, 255));
      p = 2'($urandom_range(0, 3));
      s = 1'($urandom_range(0, 1));
      m = 1'($urandom_range(0, 1));
      send(1'b0, d, p, s, m, 1'b0);
      wait_done(1'b0, 1'b1, c);
      check_val("len_rand_w8", c, frame_len(8, p, s));
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk);
        #1;
      end
    end

    // DATA_W=5, par_mode=11, 0x15
    send(1'b1, 9'h015, 2'b11, 1'b0, 1'b0, 1'b0);
    wait_done(1'b1, 1'b1, c);
    check_val("len_w5_15", c, 28);

    for (int i = 0; i < 8; i++) begin
      d = 9'($urandom_range(0, 31));
      p = 2'($urandom_range(0, 3));
      s = 1'($urandom_range(0, 1));
      m = 1'($urandom_range(0, 1));
      send(1'b1, d, p, s, m, 1'b0);
      wait_done(1'b1, 1'b1, c);
      check_val("len_rand_w5", c, frame_len(5, p, s));
    end

    repeat (4) @(posedge clk);
    #1;
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin : watchdog
    #400000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
